// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the JTAG memory bridge data stage.
package jtag_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Status bit positions inside the 3-bit status field above DATA
    localparam int ST_BUSY = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_OVR  = 2;

    localparam int DEFAULT_TIMEOUT_CYC = 1024;

    // Data register length: DATA plus BUSY, ERR and OVR
    function automatic int DR_W(input int dataW);
        return dataW + 3;
    endfunction

endpackage

// File: rtl/jtag_dr_shift.sv
// Generic JTAG capture/shift/update data register, LSB shifted out first.
// Capture beats update, update beats shift, all qualified by select.
module jtag_dr_shift
    import jtag_bridge_pkg::*;
#(
    parameter int W     = 35,
    parameter int UPD_W = W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_sel,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_update,
    input  logic             i_tdi,
    input  logic [W-1:0]     i_capture_val,
    output logic             o_tdo,
    output logic [UPD_W-1:0] o_update_val,
    output logic             o_update_pulse
);

    logic [W-1:0] r_sr;

    // Shift register: capture, hold on update, otherwise shift toward bit 0
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sr <= '0;
        end else if (i_sel && i_capture) begin
            r_sr <= i_capture_val;
        end else if (i_sel && i_update) begin
            r_sr <= r_sr;
        end else if (i_sel && i_shift) begin
            r_sr <= {i_tdi, r_sr[W-1:1]};
        end
    end

    // Serial out, parallel update value and update strobe
    always_comb begin
        o_tdo          = r_sr[0];
        o_update_val   = r_sr[UPD_W-1:0];
        o_update_pulse = i_sel && i_update && !i_capture;
    end

endmodule

// File: rtl/jtag_mem_bridge.sv
// JTAG data stage and single-outstanding bus master, all on TCK.
// Optional macro JTAG_BRIDGE_TIMEOUT_EN adds an abort counter for
// accesses the bus never answers.
module jtag_mem_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef JTAG_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
`endif
) (
    input  logic              i_TCK,
    input  logic              i_RESET,
    input  logic              i_SEL,
    input  logic              i_CAPTURE,
    input  logic              i_SHIFT,
    input  logic              i_UPDATE,
    input  logic              i_TDI,
    output logic              o_TDO,
    input  logic              i_WR,
    input  logic [31:0]       i_ADDR,
    input  logic              i_ADDR_UPD,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [31:0]       o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_err
);

    localparam int          DRW      = DR_W(DATA_W);
    localparam logic [31:0] PTR_STEP = 32'(DATA_W / 8);

    state_t              r_state;
    state_t              w_nextState;
    logic [31:0]         r_ptr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ovr;
    logic                r_err;

    logic                w_busy;
    logic                w_idle;
    logic                w_capture;
    logic                w_updPulse;
    logic [DATA_W-1:0]   w_drData;
    logic [2:0]          w_status;
    logic [DRW-1:0]      w_captureVal;
    logic                w_launch;
    logic                w_done;
    logic                w_timeout;
    logic                w_ovrSet;
    logic                w_errSet;

    jtag_dr_shift #(
        .W     (DRW),
        .UPD_W (DATA_W)
    ) u_dr (
        .i_clk          (i_TCK),
        .i_reset        (i_RESET),
        .i_sel          (i_SEL),
        .i_capture      (i_CAPTURE),
        .i_shift        (i_SHIFT),
        .i_update       (i_UPDATE),
        .i_tdi          (i_TDI),
        .i_capture_val  (w_captureVal),
        .o_tdo          (o_TDO),
        .o_update_val   (w_drData),
        .o_update_pulse (w_updPulse)
    );

`ifdef JTAG_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] r_tmoCnt;

    // Abort counter: restarts with each access, runs while not idle
    always_ff @(posedge i_TCK) begin
        if (i_RESET) begin
            r_tmoCnt <= '0;
        end else if (w_launch) begin
            r_tmoCnt <= '0;
        end else if (w_busy) begin
            r_tmoCnt <= r_tmoCnt + 16'd1;
        end
    end

    // A real response on the final cycle still counts as a normal completion
    assign w_timeout = w_busy && (r_tmoCnt == TMO_LAST) && !w_done;
`else
    assign w_timeout = 1'b0;
`endif

    // Command decode, completion and status-set events
    always_comb begin
        w_idle       = (r_state == IDLE);
        w_busy       = !w_idle;
        w_capture    = i_SEL && i_CAPTURE;
        w_launch     = w_idle && ((i_ADDR_UPD && !i_WR) || (!i_ADDR_UPD && w_updPulse));
        w_done       = (r_state == RESP) && i_bus_rvalid;
        w_ovrSet     = (w_busy && (i_ADDR_UPD || w_updPulse)) ||
                       (w_idle && i_ADDR_UPD && w_updPulse);
        w_errSet     = (w_done && i_bus_err) || w_timeout;
        w_status     = '0;
        w_status[ST_BUSY] = w_busy;
        w_status[ST_ERR]  = r_err;
        w_status[ST_OVR]  = r_ovr;
        w_captureVal = {w_status, r_rdata};
    end

    // FSM state register
    always_ff @(posedge i_TCK) begin
        if (i_RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_nextState = REQ;
            REQ:     if (w_timeout) w_nextState = IDLE;
                     else if (i_bus_gnt) w_nextState = RESP;
            RESP:    if (w_done || w_timeout) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // FSM outputs: request is asserted exactly while in REQ
    always_comb begin
        o_bus_req   = (r_state == REQ);
        o_bus_we    = r_we;
        o_bus_addr  = r_ptr;
        o_bus_wdata = r_wdata;
    end

    // Pointer, access attributes, read data and sticky status flags
    always_ff @(posedge i_TCK) begin
        if (i_RESET) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ovr   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_idle && i_ADDR_UPD) begin
                r_ptr <= i_ADDR;
            end else if (w_done) begin
                r_ptr <= r_ptr + PTR_STEP;
            end
            if (w_launch) begin
                r_we <= !i_ADDR_UPD && i_WR;
                if (!i_ADDR_UPD && i_WR) begin
                    r_wdata <= w_drData;
                end
            end
            if (w_done && !r_we) begin
                r_rdata <= i_bus_rdata;
            end
            r_ovr <= (r_ovr && !w_capture) || w_ovrSet;
            r_err <= (r_err && !w_capture) || w_errSet;
        end
    end

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Self-checking bench for jtag_mem_bridge (32-bit data). Honours
// JTAG_BRIDGE_TIMEOUT_EN when the design is built with it.
module tb_jtag_mem_bridge;

    localparam int DW  = 32;
    localparam int DRN = DW + 3;

    logic          tck = 1'b0;
    logic          reset, sel, capture, shift, update, tdi, tdo;
    logic          wr, addrUpd;
    logic [31:0]   addr;
    logic          busReq, busWe, busGnt, busRvalid, busErr;
    logic [31:0]   busAddr;
    logic [DW-1:0] busWdata, busRdata;

    int total = 0;
    int bad   = 0;

    // Reference model: access pointer, mode and status as seen over JTAG
    logic [31:0] mPtr;
    logic        mWr;
    logic [31:0] mRdata;
    logic        mErr, mOvr;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdPre;
        logic        errPre;
        logic [31:0] rdPost;
        logic        errPost;
        logic [34:0] expCap;
        logic [31:0] expAddr;
    } vec_t;

    vec_t vecs[4];

    jtag_mem_bridge #(.DATA_W(DW)) dut (
        .i_TCK        (tck),
        .i_RESET      (reset),
        .i_SEL        (sel),
        .i_CAPTURE    (capture),
        .i_SHIFT      (shift),
        .i_UPDATE     (update),
        .i_TDI        (tdi),
        .o_TDO        (tdo),
        .i_WR         (wr),
        .i_ADDR       (addr),
        .i_ADDR_UPD   (addrUpd),
        .o_bus_req    (busReq),
        .o_bus_we     (busWe),
        .o_bus_addr   (busAddr),
        .o_bus_wdata  (busWdata),
        .i_bus_gnt    (busGnt),
        .i_bus_rvalid (busRvalid),
        .i_bus_rdata  (busRdata),
        .i_bus_err    (busErr)
    );

    always #5 tck = ~tck;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [34:0] expCapture(input logic busy);
        return {mOvr, mErr, busy, mRdata};
    endfunction

    // Address-stage update pulse; WR is left driven afterwards
    task automatic addrUpdate(input logic [31:0] a, input logic w);
        addr = a; wr = w; addrUpd = 1'b1;
        @(negedge tck);
        addrUpd = 1'b0;
        mPtr = a; mWr = w;
    endtask

    // Full DR scan: capture, shift DRN bits (data LSB first), optional update
    task automatic scanDr(input logic [31:0] data, input bit doUpd, output logic [34:0] cap);
        sel = 1'b1; capture = 1'b1;
        @(negedge tck);
        capture = 1'b0; shift = 1'b1;
        for (int i = 0; i < DRN; i++) begin
            cap[i] = tdo;
            tdi = (i < DW) ? data[i] : 1'b0;
            @(negedge tck);
        end
        shift = 1'b0; tdi = 1'b0;
        if (doUpd) begin
            update = 1'b1;
            @(negedge tck);
            update = 1'b0;
        end
        sel = 1'b0;
    endtask

    // Bus slave for one access; checks request attributes, updates the model
    task automatic respond(input logic [31:0] expAddr, input logic expWe, input logic [31:0] expWd,
                           input logic [31:0] rd, input logic be, input int gd, input int rvd);
        int n = 0;
        while (!busReq && n < 200) begin
            @(negedge tck);
            n++;
        end
        checkOutput("reqSeen", {63'd0, busReq}, 64'd1);
        checkOutput("busAddr", {32'd0, busAddr}, {32'd0, expAddr});
        checkOutput("busWe", {63'd0, busWe}, {63'd0, expWe});
        if (expWe) checkOutput("busWdata", {32'd0, busWdata}, {32'd0, expWd});
        repeat (gd) @(negedge tck);
        busGnt = 1'b1;
        @(negedge tck);
        busGnt = 1'b0;
        checkOutput("reqDrop", {63'd0, busReq}, 64'd0);
        repeat (rvd) @(negedge tck);
        checkOutput("addrStable", {32'd0, busAddr}, {32'd0, expAddr});
        busRvalid = 1'b1; busRdata = rd; busErr = be;
        @(negedge tck);
        busRvalid = 1'b0; busErr = 1'b0; busRdata = '0;
        if (!expWe) mRdata = rd;
        mErr = mErr | be;
        mPtr = mPtr + 32'd4;
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [34:0] cap;
        addrUpdate(v.addr, v.wr);
        if (!v.wr) respond(v.addr, 1'b0, 32'd0, v.rdPre, v.errPre, 1, 1);
        scanDr(v.wdata, 1'b1, cap);
        checkOutput("vecCapture", {29'd0, cap}, {29'd0, v.expCap});
        mOvr = 1'b0; mErr = 1'b0;
        respond(v.expAddr, v.wr, v.wdata, v.rdPost, v.errPost, 0, 2);
    endtask

    initial begin
        logic [34:0] cap;
        logic [31:0] d;
        int n;

        reset = 1'b1; sel = 0; capture = 0; shift = 0; update = 0; tdi = 0;
        wr = 0; addr = '0; addrUpd = 0; busGnt = 0; busRvalid = 0; busErr = 0; busRdata = '0;
        mPtr = '0; mWr = 0; mRdata = '0; mErr = 0; mOvr = 0;
        repeat (3) @(negedge tck);
        reset = 1'b0;
        @(negedge tck);

        checkOutput("rstReq", {63'd0, busReq}, 64'd0);
        checkOutput("rstWe", {63'd0, busWe}, 64'd0);
        checkOutput("rstAddr", {32'd0, busAddr}, 64'd0);
        checkOutput("rstWdata", {32'd0, busWdata}, 64'd0);
        checkOutput("rstTdo", {63'd0, tdo}, 64'd0);
        scanDr(32'd0, 1'b0, cap);
        checkOutput("rstCapture", {29'd0, cap}, 64'd0);

        // Table vectors: write, read with prefetch, wrap with bus error, error clear
        vecs[0] = '{1'b1, 32'h8000_0000, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 1'b0,
                    35'h0_0000_0000, 32'h8000_0000};
        vecs[1] = '{1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0BAD_F00D, 1'b0,
                    35'h0_DEAD_BEEF, 32'h0000_0104};
        vecs[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_5A5A, 1'b1, 32'h1111_2222, 1'b1,
                    35'h2_A5A5_5A5A, 32'h0000_0000};
        vecs[3] = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 1'b0,
                    35'h2_1111_2222, 32'h0000_0020};
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
        scanDr(32'd0, 1'b0, cap);
        checkOutput("errCleared", {29'd0, cap}, {29'd0, 35'h0_1111_2222});
        mErr = 1'b0;

        // Write burst: pointer steps by one word per update
        addrUpdate(32'h8000_0000, 1'b1);
        scanDr(32'h1234_5678, 1'b1, cap);
        respond(32'h8000_0000, 1'b1, 32'h1234_5678, 32'h0, 1'b0, 0, 0);
        scanDr(32'h9ABC_DEF0, 1'b1, cap);
        respond(32'h8000_0004, 1'b1, 32'h9ABC_DEF0, 32'h0, 1'b0, 3, 0);

        // Overrun: update while the previous access waits for a grant
        addrUpdate(32'h0000_0200, 1'b1);
        scanDr(32'h0000_AAAA, 1'b1, cap);
        scanDr(32'h0000_BBBB, 1'b1, cap);
        checkOutput("busyCapture", {29'd0, cap}, {29'd0, expCapture(1'b1)});
        mOvr = 1'b1;
        scanDr(32'd0, 1'b0, cap);
        checkOutput("ovrCapture", {29'd0, cap}, {29'd0, expCapture(1'b1)});
        mOvr = 1'b0;
        respond(32'h0000_0200, 1'b1, 32'h0000_AAAA, 32'h0, 1'b0, 0, 1);
        scanDr(32'h0000_CCCC, 1'b1, cap);
        checkOutput("ovrCleared", {29'd0, cap}, {29'd0, expCapture(1'b0)});
        respond(32'h0000_0204, 1'b1, 32'h0000_CCCC, 32'h0, 1'b0, 1, 0);

        // Randomized traffic checked against the model
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                d = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
                addrUpdate(d, 1'($urandom_range(0, 1)));
                if (!mWr) respond(mPtr, 1'b0, 32'd0, $urandom, 1'($urandom_range(0, 3) == 0),
                                  $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                d = $urandom;
                scanDr(d, 1'b1, cap);
                checkOutput("randCapture", {29'd0, cap}, {29'd0, expCapture(1'b0)});
                mOvr = 1'b0; mErr = 1'b0;
                respond(mPtr, mWr, d, $urandom, 1'($urandom_range(0, 3) == 0),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        scanDr(32'd0, 1'b0, cap);
        checkOutput("randFinal", {29'd0, cap}, {29'd0, expCapture(1'b0)});
        mOvr = 1'b0; mErr = 1'b0;

        // Reset while a read waits in REQ; a late response must be ignored
        addrUpdate(32'h0000_0300, 1'b0);
        checkOutput("reqBeforeReset", {63'd0, busReq}, 64'd1);
        reset = 1'b1;
        @(negedge tck);
        checkOutput("reqAfterReset", {63'd0, busReq}, 64'd0);
        reset = 1'b0;
        mPtr = '0; mRdata = '0; mErr = 0; mOvr = 0;
        busRvalid = 1'b1; busRdata = 32'h5555_5555;
        @(negedge tck);
        busRvalid = 1'b0; busRdata = '0;
        scanDr(32'd0, 1'b0, cap);
        checkOutput("lateRvalid", {29'd0, cap}, 64'd0);
        checkOutput("ptrAfterReset", {32'd0, busAddr}, 64'd0);

        // Unanswered access: abort with ERR, or keep waiting without the counter
        addrUpdate(32'h0000_0400, 1'b0);
        n = 0;
        while (busReq && n < 1100) begin
            @(negedge tck);
            n++;
        end
`ifdef JTAG_BRIDGE_TIMEOUT_EN
        checkOutput("timeoutCycles", 64'(n), 64'd1024);
        checkOutput("timeoutReq", {63'd0, busReq}, 64'd0);
        mErr = 1'b1;
        scanDr(32'd0, 1'b0, cap);
        checkOutput("timeoutCapture", {29'd0, cap}, {29'd0, expCapture(1'b0)});
        checkOutput("timeoutPtr", {32'd0, busAddr}, 64'h400);
`else
        checkOutput("noTimeoutReq", {63'd0, busReq}, 64'd1);
        respond(32'h0000_0400, 1'b0, 32'd0, 32'h7777_0000, 1'b0, 0, 0);
        scanDr(32'd0, 1'b0, cap);
        checkOutput("lateReadCapture", {29'd0, cap}, {29'd0, expCapture(1'b0)});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
